bash_f_iter: RTL and testbench

//  Iterative bash-f sponge permutation (STB 34.101.77): 1536-bit state of 24 64-bit words.

---
 rtl/bash_f_iter.sv | 131 +++++++++++++
 tb/tb_bash_f_iter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bash_f_iter.sv
// bash_f_iter: iterative bash-f sponge permutation, one full round per clock.
// The 1536-bit state is 24 64-bit words, S0 in the top bits.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   data_sel  0 = load data_i, 1 = run rounds (holds once 24 rounds are done)
//   data_i    input state {S0..S23}
//   data_o    state register, same packing as data_i
//   done_o    high once the 24th round has completed
module bash_f_iter (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_sel,
  input  logic [1535:0] data_i,
  output logic [1535:0] data_o,
  output logic          done_o
);

  localparam int unsigned SLEN    = 64;
  localparam int unsigned WORDS   = 24;
  localparam int unsigned ROUNDS  = 24;
  localparam int unsigned STATE_W = SLEN * WORDS;
  localparam int unsigned CNT_W   = 5;

  localparam logic [SLEN-1:0] C1   = 64'h3BF5080AC8BA94B1;
  localparam logic [SLEN-1:0] POLY = 64'hDC2BE1997FE0D8AE;

  // Rotation amounts for each of the eight column S-box instances.
  localparam int unsigned M1 [8] = '{8, 56, 8, 56, 8, 56, 8, 56};
  localparam int unsigned N1 [8] = '{53, 51, 37, 3, 21, 19, 5, 35};
  localparam int unsigned M2 [8] = '{14, 34, 46, 2, 14, 34, 46, 2};
  localparam int unsigned N2 [8] = '{1, 7, 49, 23, 33, 39, 17, 55};

  // Word permutation: new S[k] = old S[P[k]].
  localparam int unsigned P [24] = '{15, 10, 9, 12, 11, 14, 13, 8,
                                     17, 16, 19, 18, 21, 20, 23, 22,
                                     6, 3, 0, 5, 2, 7, 4, 1};

  logic [STATE_W-1:0] state_q;
  logic [SLEN-1:0]    c_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;

  logic [SLEN-1:0]    s_w    [WORDS];
  logic [SLEN-1:0]    mix_w  [WORDS];
  logic [SLEN-1:0]    perm_w [WORDS];
  logic [STATE_W-1:0] round_state;
  logic [SLEN-1:0]    c_next;

  // Rotate left; amounts are always in 1..63.
  function automatic logic [SLEN-1:0] rotl(input logic [SLEN-1:0] x, input int unsigned n);
    return (x << n) | (x >> (SLEN - n));
  endfunction

  // bash-s S-box on one column (W0, W1, W2), returned as {W0, W1, W2}.
  function automatic logic [3*SLEN-1:0] bash_s(
    input logic [SLEN-1:0] w0_in,
    input logic [SLEN-1:0] w1_in,
    input logic [SLEN-1:0] w2_in,
    input int unsigned     m1,
    input int unsigned     n1,
    input int unsigned     m2,
    input int unsigned     n2
  );
    logic [SLEN-1:0] w0, w1, w2, t0, t1, t2;
    w0 = w0_in;
    w1 = w1_in;
    w2 = w2_in;
    t0 = rotl(w0, m1);
    w0 = w0 ^ w1 ^ w2;
    t1 = w1 ^ rotl(w0, n1);
    w1 = t0 ^ t1;
    w2 = w2 ^ rotl(w2, m2) ^ rotl(t1, n2);
    t0 = ~w2 | w1;
    t1 = w0 | w2;
    t2 = w0 & w1;
    w1 = w1 ^ t1;
    w2 = w2 ^ t2;
    w0 = w0 ^ t0;
    return {w0, w1, w2};
  endfunction

  // One full round: eight parallel S-boxes, word permutation, constant injection.
  always_comb begin
    round_state = '0;
    for (int k = 0; k < 24; k++) begin
      s_w[k] = state_q[STATE_W-1-SLEN*k -: SLEN];
    end
    for (int j = 0; j < 8; j++) begin
      {mix_w[j], mix_w[8+j], mix_w[16+j]} =
        bash_s(s_w[j], s_w[8+j], s_w[16+j], M1[j], N1[j], M2[j], N2[j]);
    end
    for (int k = 0; k < 24; k++) begin
      perm_w[k] = mix_w[P[k]];
    end
    perm_w[23] = perm_w[23] ^ c_q;
    for (int k = 0; k < 24; k++) begin
      round_state[STATE_W-1-SLEN*k -: SLEN] = perm_w[k];
    end
  end

  // Round-constant LFSR step.
  always_comb begin
    c_next = c_q >> 1;
    if (c_q[0]) c_next = (c_q >> 1) ^ POLY;
  end

  // State, constant and round counter; reset > load > iterate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      c_q     <= C1;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (!data_sel) begin
      state_q <= data_i;
      c_q     <= C1;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (cnt_q < CNT_W'(ROUNDS)) begin
      state_q <= round_state;
      c_q     <= c_next;
      cnt_q   <= cnt_q + CNT_W'(1);
      done_q  <= (cnt_q == CNT_W'(ROUNDS - 1));
    end
  end

  assign data_o = state_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_bash_f_iter.sv
// Self-checking bench for bash_f_iter against a word-array reference model.
module tb_bash_f_iter;

  typedef logic [63:0]   word_t;
  typedef logic [1535:0] state_t;

  localparam word_t C1 = 64'h3BF5080AC8BA94B1;
  localparam word_t C2 = 64'hC1D1659C1BBD92F6;

  logic   clk;
  logic   rst;
  logic   data_sel;
  state_t data_i;
  state_t data_o;
  logic   done_o;

  int vectors;
  int miscompares;

  int m1t [8] = '{8, 56, 8, 56, 8, 56, 8, 56};
  int n1t [8] = '{53, 51, 37, 3, 21, 19, 5, 35};
  int m2t [8] = '{14, 34, 46, 2, 14, 34, 46, 2};
  int n2t [8] = '{1, 7, 49, 23, 33, 39, 17, 55};
  int pt  [24] = '{15, 10, 9, 12, 11, 14, 13, 8,
                   17, 16, 19, 18, 21, 20, 23, 22,
                   6, 3, 0, 5, 2, 7, 4, 1};

  bash_f_iter dut (
    .clk      (clk),
    .rst      (rst),
    .data_sel (data_sel),
    .data_i   (data_i),
    .data_o   (data_o),
    .done_o   (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t rol(input word_t x, input int n);
    logic [127:0] d;
    d = {x, x} << n;
    return d[127:64];
  endfunction

  // Reference: apply nr rounds of bash-f starting from constant C1.
  function automatic state_t ref_perm(input state_t st, input int nr);
    word_t s [24];
    word_t ns [24];
    word_t c, w0, w1, w2, t0, t1, t2;
    state_t r;
    c = C1;
    for (int k = 0; k < 24; k++) s[k] = st[1535-64*k -: 64];
    for (int rr = 0; rr < nr; rr++) begin
      for (int j = 0; j < 8; j++) begin
        w0 = s[j]; w1 = s[8+j]; w2 = s[16+j];
        t0 = rol(w0, m1t[j]);
        w0 = w0 ^ w1 ^ w2;
        t1 = w1 ^ rol(w0, n1t[j]);
        w1 = t0 ^ t1;
        w2 = w2 ^ rol(w2, m2t[j]) ^ rol(t1, n2t[j]);
        t0 = ~w2 | w1; t1 = w0 | w2; t2 = w0 & w1;
        s[j] = w0 ^ t0; s[8+j] = w1 ^ t1; s[16+j] = w2 ^ t2;
      end
      for (int k = 0; k < 24; k++) ns[k] = s[pt[k]];
      for (int k = 0; k < 24; k++) s[k] = ns[k];
      s[23] = s[23] ^ c;
      if (c[0]) c = (c >> 1) ^ 64'hDC2BE1997FE0D8AE;
      else      c = c >> 1;
    end
    for (int k = 0; k < 24; k++) r[1535-64*k -: 64] = s[k];
    return r;
  endfunction

  function automatic state_t rand_state();
    state_t r;
    for (int i = 0; i < 48; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input state_t x);
    data_sel = 1'b0;
    data_i   = x;
    tick();
    data_sel = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; data_sel = 1'b1; data_i = rand_state();
    tick();
    rst = 1'b0;
    vectors++;
    if (data_o !== '0 || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: data_o=%h done_o=%b, required 0/0", data_o[63:0], done_o);
    end
  endtask

  task automatic test_zero_round();
    state_t exp;
    exp = '0;
    for (int k = 16; k < 23; k++) exp[1535-64*k -: 64] = 64'hFFFFFFFFFFFFFFFF;
    exp[63:0] = 64'hC40AF7F537456B4E;
    load('0);
    tick();
    vectors++;
    if (data_o !== exp || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_round: S23=%h done=%b, required S23=%h done=0", data_o[63:0], done_o, exp[63:0]);
    end
    vectors++;
    if (dut.c_q !== C2) begin
      miscompares++;
      $display("FAIL const_chain: C=%h, required %h", dut.c_q, C2);
    end
    tick();
    exp = ref_perm('0, 2);
    vectors++;
    if (data_o !== exp) begin
      miscompares++;
      $display("FAIL two_rounds: S23=%h, required %h", data_o[63:0], exp[63:0]);
    end
  endtask

  // Full permutations of random states; also checks done timing and hold.
  task automatic test_full(input int n);
    state_t x, exp, held;
    for (int v = 0; v < n; v++) begin
      x = rand_state();
      load(x);
      vectors++;
      if (data_o !== x || done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL load %0d: S0=%h done=%b, required S0=%h done=0", v, data_o[1535:1472], done_o, x[1535:1472]);
      end
      for (int r = 1; r <= 24; r++) begin
        tick();
        if (r == 12) begin
          exp = ref_perm(x, 12);
          vectors++;
          if (data_o !== exp) begin
            miscompares++;
            $display("FAIL mid12 %0d: S0=%h, required %h", v, data_o[1535:1472], exp[1535:1472]);
          end
        end
        if (r == 23) begin
          vectors++;
          if (done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL early_done %0d: done=%b, required 0", v, done_o);
          end
        end
      end
      exp = ref_perm(x, 24);
      vectors++;
      if (data_o !== exp || done_o !== 1'b1) begin
        miscompares++;
        $display("FAIL full %0d: S0=%h done=%b, required S0=%h done=1", v, data_o[1535:1472], done_o, exp[1535:1472]);
      end
    end
    held = data_o;
    for (int e = 0; e < 10; e++) begin
      tick();
      vectors++;
      if (data_o !== held || done_o !== 1'b1) begin
        miscompares++;
        $display("FAIL hold %0d: S0=%h done=%b, required S0=%h done=1", e, data_o[1535:1472], done_o, held[1535:1472]);
      end
    end
  endtask

  task automatic test_abort();
    state_t x, exp;
    x = rand_state();
    load(x);
    for (int r = 0; r < 5; r++) tick();
    exp = ref_perm(x, 5);
    vectors++;
    if (data_o !== exp) begin
      miscompares++;
      $display("FAIL abort_r5: S0=%h, required %h", data_o[1535:1472], exp[1535:1472]);
    end
    load(x);
    vectors++;
    if (data_o !== x || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reload: S0=%h done=%b, required S0=%h done=0", data_o[1535:1472], done_o, x[1535:1472]);
    end
    for (int r = 0; r < 24; r++) tick();
    exp = ref_perm(x, 24);
    vectors++;
    if (data_o !== exp || done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rerun: S0=%h done=%b, required S0=%h done=1", data_o[1535:1472], done_o, exp[1535:1472]);
    end
  endtask

  // Reset mid-run with data_sel still high, then iterate from the zero state.
  task automatic test_mid_reset();
    state_t exp;
    load(rand_state());
    for (int r = 0; r < 7; r++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (data_o !== '0 || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: S0=%h done=%b, required 0/0", data_o[1535:1472], done_o);
    end
    tick();
    exp = ref_perm('0, 1);
    vectors++;
    if (data_o !== exp) begin
      miscompares++;
      $display("FAIL post_reset_round: S23=%h, required %h", data_o[63:0], exp[63:0]);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    data_sel = 1'b0;
    data_i = '0;
    test_reset();
    test_zero_round();
    test_full(4);
    test_abort();
    test_mid_reset();
    test_full(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
